// File: rtl/stack_pkg.sv
// Shared definitions for the stack sequencer: command encodings, one-hot
// FSM states and error-flag bit positions.
package stack_pkg;

  localparam logic [2:0] OP_PUSH1 = 3'b000;
  localparam logic [2:0] OP_PUSH2 = 3'b001;
  localparam logic [2:0] OP_PUSH3 = 3'b010;
  localparam logic [2:0] OP_PULL1 = 3'b100;
  localparam logic [2:0] OP_PULL2 = 3'b101;
  localparam logic [2:0] OP_PULL3 = 3'b110;

  typedef logic [4:0] state_t;
  localparam state_t ST_IDLE      = 5'b00001;
  localparam state_t ST_PUSH      = 5'b00010;
  localparam state_t ST_PULL      = 5'b00100;
  localparam state_t ST_PULL_LAST = 5'b01000;
  localparam state_t ST_DONE      = 5'b10000;

  localparam int ERR_W         = 3;
  localparam int ERR_PUSH_WRAP = 0;
  localparam int ERR_PULL_WRAP = 1;
  localparam int ERR_ILLEGAL   = 2;

  // Low two bits of 2'b11 mark the two illegal encodings.
  function automatic logic op_legal(input logic [2:0] op);
    return op[1:0] != 2'b11;
  endfunction

  function automatic logic op_is_pull(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic [1:0] op_bytes(input logic [2:0] op);
    return (op[1:0] == 2'b11) ? 2'd1 : op[1:0] + 2'd1;
  endfunction

endpackage

// File: rtl/stack_ptr.sv
// Stack pointer register with load/increment/decrement and wrap detection.
module stack_ptr #(
  parameter int              SP_W     = 8,
  parameter logic [SP_W-1:0] SP_RESET = 8'hFD
) (
  input  logic            CLK,
  input  logic            R,
  input  logic            load,
  input  logic [SP_W-1:0] load_val,
  input  logic            inc,
  input  logic            dec,
  output logic [SP_W-1:0] sp,
  output logic            inc_wrap,
  output logic            dec_wrap
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge CLK or posedge R) begin
    if (R)         sp <= SP_RESET;
    else if (load) sp <= load_val;
    else if (inc)  sp <= sp + 1'b1;
    else if (dec)  sp <= sp - 1'b1;
  end

  assign inc_wrap = inc && (sp == '1);
  assign dec_wrap = dec && (sp == '0);

endmodule

// File: rtl/stack_seq.sv
// Stack sequencer: expands 1-3 byte push/pull commands into back-to-back
// memory cycles on the stack page and owns the stack pointer.
module stack_seq
  import stack_pkg::*;
#(
  parameter int                DW         = 8,
  parameter int                AW         = 16,
  parameter int                SP_W       = 8,
  parameter int                PAGE_W     = 8,
  parameter logic [PAGE_W-1:0] STACK_PAGE = 8'h01,
  parameter logic [SP_W-1:0]   SP_RESET   = 8'hFD
) (
  input  logic            CLK,
  input  logic            R,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [3*DW-1:0] wdata,
  output logic            rsp_valid,
  output logic [3*DW-1:0] rsp_data,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic [SP_W-1:0] sp,
  input  logic            sp_wr,
  input  logic [SP_W-1:0] sp_wdata,
  output logic [ERR_W-1:0] err
);

  state_t           state, state_nx;
  logic [1:0]       n_q, cnt;
  logic [3*DW-1:0]  data_q, rsp_q;
  logic [ERR_W-1:0] err_q;
  logic             accept, sp_load, sp_inc, sp_dec, inc_wrap, dec_wrap;
  logic [1:0]       cap_idx;
  logic [SP_W-1:0]  sp_up;

  stack_ptr #(.SP_W(SP_W), .SP_RESET(SP_RESET)) u_ptr (
    .CLK      (CLK),
    .R        (R),
    .load     (sp_load),
    .load_val (sp_wdata),
    .inc      (sp_inc),
    .dec      (sp_dec),
    .sp       (sp),
    .inc_wrap (inc_wrap),
    .dec_wrap (dec_wrap)
  );

  always_ff @(posedge CLK or posedge R) begin
    if (R) state <= ST_IDLE;
    else   state <= state_nx;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:
        if (accept)
          state_nx = !op_legal(cmd_op)  ? ST_DONE :
                     op_is_pull(cmd_op) ? ST_PULL : ST_PUSH;
      ST_PUSH:      if (cnt == n_q - 2'd1) state_nx = ST_DONE;
      ST_PULL:      if (cnt == n_q - 2'd1) state_nx = ST_PULL_LAST;
      ST_PULL_LAST: state_nx = ST_DONE;
      ST_DONE:      state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  assign sp_up = sp + 1'b1;

  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_addr  = AW'({STACK_PAGE, sp});
    sp_load   = 1'b0;
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = !sp_wr;
        sp_load   = sp_wr;
      end
      ST_PUSH: begin
        mem_we    = 1'b1;
        mem_wdata = data_q[3*DW-1 -: DW];
        sp_dec    = 1'b1;
      end
      ST_PULL: begin
        mem_addr = AW'({STACK_PAGE, sp_up});
        sp_inc   = 1'b1;
      end
      ST_DONE: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = cmd_valid && cmd_ready;

  // Read data lags the address by one cycle, so each capture lands one byte
  // behind the address counter; PULL_LAST collects the final byte.
  assign cap_idx = (state == ST_PULL_LAST) ? n_q - 2'd1 : cnt - 2'd1;

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      n_q    <= '0;
      cnt    <= '0;
      data_q <= '0;
      rsp_q  <= '0;
      err_q  <= '0;
    end else if (accept) begin
      n_q    <= op_bytes(cmd_op);
      cnt    <= '0;
      // Left-align the payload so the most significant pushed byte is on top.
      data_q <= wdata << (DW * (3 - int'(op_bytes(cmd_op))));
      rsp_q  <= '0;
      if (!op_legal(cmd_op)) err_q[ERR_ILLEGAL] <= 1'b1;
    end else if (sp_load) begin
      err_q <= '0;
    end else begin
      case (state)
        ST_PUSH: begin
          data_q <= data_q << DW;
          cnt    <= cnt + 2'd1;
          if (dec_wrap) err_q[ERR_PUSH_WRAP] <= 1'b1;
        end
        ST_PULL: begin
          if (cnt != 2'd0) rsp_q[DW*int'(cap_idx) +: DW] <= mem_rdata;
          cnt <= cnt + 2'd1;
          if (inc_wrap) err_q[ERR_PULL_WRAP] <= 1'b1;
        end
        ST_PULL_LAST: rsp_q[DW*int'(cap_idx) +: DW] <= mem_rdata;
        default: ;
      endcase
    end
  end

  assign rsp_data = rsp_q;
  assign err      = err_q;

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq with a byte-wide synchronous-read memory model.
module tb_stack_seq;
  import stack_pkg::*;

  logic        CLK = 1'b0;
  logic        R;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [23:0] wdata, rsp_data;
  logic        rsp_valid;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  sp, sp_wdata;
  logic        sp_wr;
  logic [2:0]  err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [0:65535];

  stack_seq dut (
    .CLK       (CLK),
    .R         (R),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .wdata     (wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .sp        (sp),
    .sp_wr     (sp_wr),
    .sp_wdata  (sp_wdata),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Presents a command for one edge; returns one step into cycle 1.
  task automatic issue(input logic [2:0] op, input logic [23:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    wdata     = data;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    R = 1'b1; cmd_valid = 1'b0; cmd_op = 3'b000; wdata = '0;
    sp_wr = 1'b0; sp_wdata = '0;
    step(); step();
    R = 1'b0;
    step();
    check("rst_sp", 32'(sp), 32'hFD);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'h01FD);
    check("rst_wdata", 32'(mem_wdata), 32'd0);

    // PUSH2 0x1234: 12 then 34, pointer FD -> FB
    issue(OP_PUSH2, 24'h001234);
    check("push2_c1_we", 32'(mem_we), 32'd1);
    check("push2_c1_addr", 32'(mem_addr), 32'h01FD);
    check("push2_c1_data", 32'(mem_wdata), 32'h12);
    check("push2_c1_ready", 32'(cmd_ready), 32'd0);
    step();
    check("push2_c2_addr", 32'(mem_addr), 32'h01FC);
    check("push2_c2_data", 32'(mem_wdata), 32'h34);
    check("push2_c2_sp", 32'(sp), 32'hFC);
    step();
    check("push2_c3_rsp_valid", 32'(rsp_valid), 32'd1);
    check("push2_c3_rsp_data", 32'(rsp_data), 32'd0);
    check("push2_c3_we", 32'(mem_we), 32'd0);
    check("push2_c3_sp", 32'(sp), 32'hFB);
    check("push2_mem_fd", 32'(mem[16'h01FD]), 32'h12);
    check("push2_mem_fc", 32'(mem[16'h01FC]), 32'h34);
    step();
    check("push2_c4_ready", 32'(cmd_ready), 32'd1);
    check("push2_c4_rsp_valid", 32'(rsp_valid), 32'd0);

    // PULL2 back: reads FC then FD
    issue(OP_PULL2, 24'h0);
    check("pull2_c1_addr", 32'(mem_addr), 32'h01FC);
    check("pull2_c1_we", 32'(mem_we), 32'd0);
    step();
    check("pull2_c2_addr", 32'(mem_addr), 32'h01FD);
    check("pull2_c2_sp", 32'(sp), 32'hFC);
    step();
    check("pull2_c3_rsp_valid", 32'(rsp_valid), 32'd0);
    check("pull2_c3_sp", 32'(sp), 32'hFD);
    step();
    check("pull2_c4_rsp_valid", 32'(rsp_valid), 32'd1);
    check("pull2_c4_rsp_data", 32'(rsp_data), 32'h001234);
    step();
    check("pull2_c5_ready", 32'(cmd_ready), 32'd1);
    check("pull2_hold_data", 32'(rsp_data), 32'h001234);

    // Pointer wrap on push at 00 and pull at FF
    sp_wr = 1'b1; sp_wdata = 8'h00;
    step();
    sp_wr = 1'b0;
    check("load00_sp", 32'(sp), 32'h00);
    issue(OP_PUSH1, 24'h0000AA);
    check("wrap_push_addr", 32'(mem_addr), 32'h0100);
    check("wrap_push_data", 32'(mem_wdata), 32'hAA);
    step();
    check("wrap_push_sp", 32'(sp), 32'hFF);
    check("wrap_push_err", 32'(err), 32'b001);
    check("wrap_push_rsp_valid", 32'(rsp_valid), 32'd1);
    step();
    issue(OP_PULL1, 24'h0);
    check("wrap_pull_addr", 32'(mem_addr), 32'h0100);
    step();
    check("wrap_pull_sp", 32'(sp), 32'h00);
    step();
    check("wrap_pull_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wrap_pull_rsp_data", 32'(rsp_data), 32'h0000AA);
    check("wrap_pull_err", 32'(err), 32'b011);
    step();

    // sp_wr wins over a simultaneous command
    sp_wr = 1'b1; sp_wdata = 8'h80;
    cmd_valid = 1'b1; cmd_op = OP_PUSH1; wdata = 24'h000055;
    #1;
    check("spwr_ready_low", 32'(cmd_ready), 32'd0);
    step();
    sp_wr = 1'b0; cmd_valid = 1'b0;
    #1;
    check("spwr_sp", 32'(sp), 32'h80);
    check("spwr_err_clr", 32'(err), 32'd0);
    check("spwr_no_we", 32'(mem_we), 32'd0);
    check("spwr_ready", 32'(cmd_ready), 32'd1);

    // Illegal op: straight to DONE
    issue(3'b011, 24'hFFFFFF);
    check("ill_rsp_valid", 32'(rsp_valid), 32'd1);
    check("ill_we", 32'(mem_we), 32'd0);
    check("ill_err", 32'(err), 32'b100);
    check("ill_rsp_data", 32'(rsp_data), 32'd0);
    check("ill_sp", 32'(sp), 32'h80);
    step();
    check("ill_ready", 32'(cmd_ready), 32'd1);

    // PUSH3 then PULL3: byte order and reassembly
    sp_wr = 1'b1; sp_wdata = 8'hFD;
    step();
    sp_wr = 1'b0;
    issue(OP_PUSH3, 24'hA1B2C3);
    check("push3_c1_data", 32'(mem_wdata), 32'hA1);
    step();
    check("push3_c2_data", 32'(mem_wdata), 32'hB2);
    step();
    check("push3_c3_addr", 32'(mem_addr), 32'h01FB);
    check("push3_c3_data", 32'(mem_wdata), 32'hC3);
    step();
    check("push3_c4_rsp_valid", 32'(rsp_valid), 32'd1);
    check("push3_c4_sp", 32'(sp), 32'hFA);
    step();
    issue(OP_PULL3, 24'h0);
    check("pull3_c1_addr", 32'(mem_addr), 32'h01FB);
    step(); step(); step();
    check("pull3_c4_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    check("pull3_c5_rsp_valid", 32'(rsp_valid), 32'd1);
    check("pull3_c5_rsp_data", 32'(rsp_data), 32'hA1B2C3);
    check("pull3_c5_sp", 32'(sp), 32'hFD);
    step();

    // Reset in the middle of a PUSH3
    issue(OP_PUSH3, 24'hC0DE5A);
    check("rpush_c1_data", 32'(mem_wdata), 32'hC0);
    step();
    #2;
    R = 1'b1;
    #1;
    check("rpush_we_drop", 32'(mem_we), 32'd0);
    check("rpush_ready", 32'(cmd_ready), 32'd1);
    check("rpush_sp", 32'(sp), 32'hFD);
    step();
    check("rpush_mem_fd", 32'(mem[16'h01FD]), 32'hC0);
    check("rpush_mem_fc", 32'(mem[16'h01FC]), 32'hB2);
    R = 1'b0;
    step();
    check("rpush_idle_addr", 32'(mem_addr), 32'h01FD);
    check("rpush_err", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stack_seq.md
# stack_seq

Parametrised stack sequencer for the 8-bit CPU datapath. It owns the stack pointer and turns single push/pull commands of 1–3 bytes into back-to-back memory cycles on the stack page. These are the sequences behind PHA/PHP/PLA/PLP, JSR/RTS and BRK/RTI. It sits between the CPU state machine (command side) and MEMORY (memory side), and frees the main FSM from per-byte stack states.

## Interface
Parameters:
- DW, 8, data byte width
- AW, 16, memory address width (must be ≥ SP_W + PAGE_W)
- SP_W, 8, stack pointer width
- PAGE_W, 8, stack page width; AW = PAGE_W + SP_W
- STACK_PAGE, 8'h01, high address part of every stack access
- SP_RESET, 8'hFD, stack pointer value after reset

Ports:
- CLK  in  1  clock; all state changes on rising edge
- R  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a CLK edge
- cmd_op  in  3  000 PUSH1, 001 PUSH2, 010 PUSH3, 100 PULL1, 101 PULL2, 110 PULL3; 011/111 illegal
- wdata  in  3*DW  push payload, sampled at acceptance
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  3*DW  pulled bytes, first pulled byte in [DW-1:0]; zero for pushes
- mem_addr  out  AW  {STACK_PAGE, pointer}
- mem_we  out  1  write strobe, one byte per cycle
- mem_wdata  out  DW  write byte
- mem_rdata  in  DW  read data, valid one cycle after mem_addr
- sp  out  SP_W  current stack pointer
- sp_wr  in  1  load stack pointer (TXS)
- sp_wdata  in  SP_W  load value
- err  out  3  sticky: [0] push wrap, [1] pull wrap, [2] illegal op

## Operation
- States, one-hot: IDLE, PUSH, PULL, PULL_LAST, DONE. cmd_ready = (state==IDLE) && !sp_wr.
- Acceptance latches cmd_op, wdata, and byte count N (1–3) into internal registers.
- PUSH, one cycle per byte:
  - mem_addr={STACK_PAGE,sp}, mem_we=1, sp<=sp-1.
  - Byte order is most significant first: byte N-1 of wdata, then N-2, …, then 0.
  - PUSH3 order is PCH, PCL, P when wdata={PCH,PCL,P}.
  - After the N-th write, go to DONE.
- PULL, one cycle per byte:
  - mem_addr={STACK_PAGE,sp+1}, sp<=sp+1, mem_we=0.
  - The data of the previous cycle's address is captured into the next rsp_data byte, lowest byte first.
  - After the N-th address, go to PULL_LAST, which captures the final byte.
  - Then go to DONE.
- DONE: rsp_valid=1 for one cycle, rsp_data held stable until the next acceptance, then IDLE.
- Illegal op: accepted, no memory cycles, err[2]<=1, next state DONE, rsp_data=0.
- Pointer wrap is modulo 2^SP_W:
  - a push at sp==0 writes address {PAGE,0}, sp becomes all-ones, err[0]<=1;
  - a pull with sp all-ones reads {PAGE,0}, err[1]<=1.
- sp_wr:
  - In IDLE: sp<=sp_wdata and err<=0; it has priority over cmd_valid in the same cycle, and the command is not accepted.
  - Outside IDLE: ignored.
- mem_addr in IDLE/DONE = {STACK_PAGE,sp}, with mem_we=0.

## Timing
- Reset values: state IDLE, sp=SP_RESET, cmd_ready=1, rsp_valid=0, rsp_data=0, mem_we=0, mem_wdata=0, err=0.
- R mid-sequence: return to IDLE asynchronously. mem_we drops in the same cycle and no further write occurs. Partially pushed bytes remain in memory.
- Cycle 0 is the accepting edge.
  - Push N: writes on cycles 1..N; rsp_valid on cycle N+1; cmd_ready on cycle N+2.
  - Pull N: addresses on cycles 1..N; rsp_valid on cycle N+2; cmd_ready on cycle N+3.
- Illegal op: rsp_valid cycle 1, cmd_ready cycle 2.
- sp reflects each decrement/increment on the edge after the corresponding memory cycle. No pointer bypass to the command side.

## Structure
- Shared package `stack_pkg`:
  - cmd_op encodings and byte-count function;
  - one-hot state constants;
  - err bit indices.
  STACK_PAGE/SP_RESET defaults belong to the CPU parameter set.
- One sub-module, `stack_ptr`:
  - SP_W-bit register with load/inc/dec;
  - wrap outputs (dec at zero, inc at all-ones);
  - asynchronous reset to SP_RESET.
- Payload shifting, byte selection and FSM stay in stack_seq.

## Test plan
- Reset → sp=8'hFD, cmd_ready=1, mem_we=0, rsp_valid=0, err=3'b000.
- PUSH2, wdata=24'h001234 → writes 8'h12@16'h01FD (cycle 1), 8'h34@16'h01FC (cycle 2); rsp_valid cycle 3; sp=8'hFB.
- Then PULL2 → reads 16'h01FC, 16'h01FD; rsp_data=24'h001234 on rsp_valid (cycle 4); sp=8'hFD.
- sp_wr=1, sp_wdata=8'h00, then PUSH1 wdata=8'hAA → write 8'hAA@16'h0100, sp=8'hFF, err[0]=1. Then PULL1 → read 16'h0100, rsp_data[7:0]=8'hAA, err[1]=1.
- sp_wr with cmd_valid same cycle → cmd not accepted, sp loaded, err cleared. Then cmd_op=3'b011 → no mem_we, rsp_valid cycle 1, err[2]=1.
- PUSH3 wdata=24'hC0DE5A, R asserted mid-cycle 2 → only 8'hC0@16'h01FD written, mem_we=0 immediately, sp=8'hFD, cmd_ready=1.
